// File: rtl/vga_timing_gen.sv
// VGA timing generator.
// A pixel prescaler divides clk down to the pixel rate and drives horizontal
// and vertical position counters. Sync, display-enable, colour, and the
// line/frame start strobes are registered one clk behind the counters.
// While en is low, timing freezes in place and the visible outputs blank.

module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int COLOR_W  = 4,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [COLOR_W-1:0] in_R,
   input  logic [COLOR_W-1:0] in_G,
   input  logic [COLOR_W-1:0] in_B,
   output logic [COLOR_W-1:0] out_R,
   output logic [COLOR_W-1:0] out_G,
   output logic [COLOR_W-1:0] out_B,
   output logic               Hsync,
   output logic               Vsync,
   output logic               de,
   output logic [10:0]        pix_x,
   output logic [10:0]        pix_y,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   // Comparisons are done at 12 bits so a window ending exactly at 2048 still works.
   localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
   localparam logic [11:0] H_SS_C   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SE_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
   localparam logic [11:0] V_SS_C   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SE_C   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);

   // Reject parameter sets the 11-bit counters or the prescaler cannot represent.
   if (CLK_DIV < 1) begin : g_chk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (H_TOTAL > 2048) begin : g_chk_htot
      $error("vga_timing_gen: horizontal total exceeds 2048");
   end
   if (V_TOTAL > 2048) begin : g_chk_vtot
      $error("vga_timing_gen: vertical total exceeds 2048");
   end

   logic [PW-1:0]      presc_r;
   logic [10:0]        pix_x_r;
   logic [10:0]        pix_y_r;
   logic [COLOR_W-1:0] out_r_r;
   logic [COLOR_W-1:0] out_g_r;
   logic [COLOR_W-1:0] out_b_r;
   logic               hsync_r;
   logic               vsync_r;
   logic               de_r;
   logic               line_start_r;
   logic               frame_start_r;

   logic [11:0]        px_s;
   logic [11:0]        py_s;
   logic               tick_s;
   logic               h_last_s;
   logic               v_last_s;
   logic               h_wrap_s;
   logic               visible_s;
   logic               h_sync_lvl_s;
   logic               v_sync_lvl_s;

   assign px_s      = {1'b0, pix_x_r};
   assign py_s      = {1'b0, pix_y_r};
   assign tick_s    = en & (presc_r == PRESC_LAST);
   assign h_last_s  = (px_s == H_LAST_C);
   assign v_last_s  = (py_s == V_LAST_C);
   assign h_wrap_s  = tick_s & h_last_s;
   assign visible_s = en & (px_s < H_ACT_C) & (py_s < V_ACT_C);

   // Decode the current position into the level each sync line should take.
   always_comb begin
      h_sync_lvl_s = ~SYNC_POL;
      v_sync_lvl_s = ~SYNC_POL;
      if ((px_s >= H_SS_C) && (px_s < H_SE_C)) begin
         h_sync_lvl_s = SYNC_POL;
      end else begin
         h_sync_lvl_s = ~SYNC_POL;
      end
      if ((py_s >= V_SS_C) && (py_s < V_SE_C)) begin
         v_sync_lvl_s = SYNC_POL;
      end else begin
         v_sync_lvl_s = ~SYNC_POL;
      end
   end

   // Pixel prescaler: counts clk cycles per pixel, frozen while disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_r <= {PW{1'b0}};
      end else if (en) begin
         if (presc_r == PRESC_LAST) begin
            presc_r <= {PW{1'b0}};
         end else begin
            presc_r <= presc_r + PRESC_ONE;
         end
      end
   end

   // Horizontal/vertical position counters advanced on each pixel tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_x_r <= 11'd0;
         pix_y_r <= 11'd0;
      end else if (tick_s) begin
         if (h_last_s) begin
            pix_x_r <= 11'd0;
            if (v_last_s) begin
               pix_y_r <= 11'd0;
            end else begin
               pix_y_r <= pix_y_r + 11'd1;
            end
         end else begin
            pix_x_r <= pix_x_r + 11'd1;
         end
      end
   end

   // Registered video outputs, one clk behind the counters; syncs hold while disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_r_r       <= {COLOR_W{1'b0}};
         out_g_r       <= {COLOR_W{1'b0}};
         out_b_r       <= {COLOR_W{1'b0}};
         de_r          <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         hsync_r       <= ~SYNC_POL;
         vsync_r       <= ~SYNC_POL;
      end else begin
         de_r          <= visible_s;
         out_r_r       <= visible_s ? in_R : {COLOR_W{1'b0}};
         out_g_r       <= visible_s ? in_G : {COLOR_W{1'b0}};
         out_b_r       <= visible_s ? in_B : {COLOR_W{1'b0}};
         line_start_r  <= h_wrap_s;
         frame_start_r <= h_wrap_s & v_last_s;
         if (en) begin
            hsync_r <= h_sync_lvl_s;
            vsync_r <= v_sync_lvl_s;
         end
      end
   end

   assign out_R       = out_r_r;
   assign out_G       = out_g_r;
   assign out_B       = out_b_r;
   assign Hsync       = hsync_r;
   assign Vsync       = vsync_r;
   assign de          = de_r;
   assign pix_x       = pix_x_r;
   assign pix_y       = pix_y_r;
   assign line_start  = line_start_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one instance with default parameters and one
// small instance (H=4/1/2/1, V=2/1/1/1, CLK_DIV=1, SYNC_POL=1).

module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic       rst_a, en_a;
   logic [3:0] in_R_a, in_G_a, in_B_a, out_R_a, out_G_a, out_B_a;
   logic       Hsync_a, Vsync_a, de_a, line_start_a, frame_start_a;
   logic [10:0] pix_x_a, pix_y_a;

   // Small instance
   logic       rst_b, en_b;
   logic [3:0] in_R_b, in_G_b, in_B_b, out_R_b, out_G_b, out_B_b;
   logic       Hsync_b, Vsync_b, de_b, line_start_b, frame_start_b;
   logic [10:0] pix_x_b, pix_y_b;

   vga_timing_gen u_dut (
      .clk(clk), .rst(rst_a), .en(en_a),
      .in_R(in_R_a), .in_G(in_G_a), .in_B(in_B_a),
      .out_R(out_R_a), .out_G(out_G_a), .out_B(out_B_a),
      .Hsync(Hsync_a), .Vsync(Vsync_a), .de(de_a),
      .pix_x(pix_x_a), .pix_y(pix_y_a),
      .line_start(line_start_a), .frame_start(frame_start_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(1), .COLOR_W(4), .SYNC_POL(1'b1)
   ) u_small (
      .clk(clk), .rst(rst_b), .en(en_b),
      .in_R(in_R_b), .in_G(in_G_b), .in_B(in_B_b),
      .out_R(out_R_b), .out_G(out_G_b), .out_B(out_B_b),
      .Hsync(Hsync_b), .Vsync(Vsync_b), .de(de_b),
      .pix_x(pix_x_b), .pix_y(pix_y_b),
      .line_start(line_start_b), .frame_start(frame_start_b)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One small-instance clk: inputs applied, then expected outputs after the edge.
   typedef struct {
      logic       en;
      logic [3:0] rgb;
      int         x;
      int         y;
      logic       hs;
      logic       de;
      logic [3:0] out;
      logic       ls;
   } vec_t;

   vec_t vecs[13];

   task automatic edge_a();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int first_hs_low, hs_low, first_r0, first_ls, ls_cnt, fs_cnt, de_cnt;
      int found, fs_at, hs_hi, vs_hi, de_b_cnt, ls_b_cnt, fs_b_cnt, ls_first;

      //            en    rgb    x  y  hs    de    out    ls
      vecs[0]  = '{1'b1, 4'hA, 1, 0, 1'b0, 1'b1, 4'hA, 1'b0};
      vecs[1]  = '{1'b1, 4'hA, 2, 0, 1'b0, 1'b1, 4'hA, 1'b0};
      vecs[2]  = '{1'b1, 4'hA, 3, 0, 1'b0, 1'b1, 4'hA, 1'b0};
      vecs[3]  = '{1'b1, 4'hA, 4, 0, 1'b0, 1'b1, 4'hA, 1'b0};
      vecs[4]  = '{1'b1, 4'hA, 5, 0, 1'b0, 1'b0, 4'h0, 1'b0};
      vecs[5]  = '{1'b1, 4'hA, 6, 0, 1'b1, 1'b0, 4'h0, 1'b0};
      vecs[6]  = '{1'b0, 4'hA, 6, 0, 1'b1, 1'b0, 4'h0, 1'b0};
      vecs[7]  = '{1'b0, 4'hA, 6, 0, 1'b1, 1'b0, 4'h0, 1'b0};
      vecs[8]  = '{1'b1, 4'hA, 7, 0, 1'b1, 1'b0, 4'h0, 1'b0};
      vecs[9]  = '{1'b1, 4'hA, 0, 1, 1'b0, 1'b0, 4'h0, 1'b1};
      vecs[10] = '{1'b1, 4'h5, 1, 1, 1'b0, 1'b1, 4'h5, 1'b0};
      vecs[11] = '{1'b0, 4'h5, 1, 1, 1'b0, 1'b0, 4'h0, 1'b0};
      vecs[12] = '{1'b1, 4'h5, 2, 1, 1'b0, 1'b1, 4'h5, 1'b0};

      rst_a = 1'b1; rst_b = 1'b1;
      en_a = 1'b1; en_b = 1'b1;
      in_R_a = 4'hF; in_G_a = 4'hF; in_B_a = 4'hF;
      in_R_b = 4'hA; in_G_b = 4'hA; in_B_b = 4'hA;
      #1;
      rst_a = 1'b0; rst_b = 1'b0;
      #1;
      // Asynchronous reset values, before any clock edge
      check("rst_async_hs_a", Hsync_a, 1);
      check("rst_async_vs_a", Vsync_a, 1);
      check("rst_async_hs_b", Hsync_b, 0);
      repeat (3) edge_a();
      check("rst_x_a", pix_x_a, 0);
      check("rst_y_a", pix_y_a, 0);
      check("rst_de_a", de_a, 0);
      check("rst_rgb_a", {out_R_a, out_G_a, out_B_a}, 0);
      check("rst_ls_fs_a", {line_start_a, frame_start_a}, 0);
      check("rst_vs_b", Vsync_b, 0);

      // ---- Default instance: first line timing ----
      rst_a = 1'b1;
      first_hs_low = -1; hs_low = 0; first_r0 = -1; first_ls = -1;
      ls_cnt = 0; fs_cnt = 0; de_cnt = 0;
      for (int k = 1; k <= 1700; k++) begin
         edge_a();
         if (first_hs_low < 0 && Hsync_a == 1'b0) first_hs_low = k;
         if (Hsync_a == 1'b0) hs_low++;
         if (first_r0 < 0 && out_R_a == 4'h0) first_r0 = k;
         if (line_start_a) begin
            ls_cnt++;
            if (first_ls < 0) first_ls = k;
         end
         if (frame_start_a) fs_cnt++;
         if (de_a) de_cnt++;
      end
      check("hs_first_low_clk", first_hs_low, 1313);
      check("hs_low_width", hs_low, 192);
      check("rgb_blank_first_clk", first_r0, 1281);
      check("line_start_first_clk", first_ls, 1600);
      check("line_start_count", ls_cnt, 1);
      check("no_frame_start_early", fs_cnt, 0);
      check("de_count", de_cnt, 1380);
      check("x_after_1700", pix_x_a, 50);
      check("y_after_1700", pix_y_a, 1);

      // ---- Default instance: freeze at pix_x=100 ----
      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         edge_a();
         if (pix_x_a == 11'd100) found = 1;
      end
      check("reach_x100", found, 1);
      en_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edge_a();
         check("freeze_x", pix_x_a, 100);
         check("freeze_de", de_a, 0);
         check("freeze_rgb", out_R_a, 0);
      end
      en_a = 1'b1;
      edge_a();
      check("resume1_x", pix_x_a, 100);
      check("resume1_de", de_a, 1);
      edge_a();
      check("resume2_x", pix_x_a, 101);

      // ---- Default instance: reset acts without a clock edge ----
      rst_a = 1'b0;
      #1;
      check("midrst_x_a", pix_x_a, 0);
      check("midrst_de_a", de_a, 0);
      check("midrst_rgb_a", out_R_a, 0);
      check("midrst_hs_a", Hsync_a, 1);

      // ---- Small instance: table-driven vectors ----
      edge_a();
      rst_b = 1'b1;
      for (int i = 0; i < 13; i++) begin
         en_b = vecs[i].en;
         in_R_b = vecs[i].rgb; in_G_b = vecs[i].rgb; in_B_b = vecs[i].rgb;
         edge_a();
         check($sformatf("vec%0d_x", i), pix_x_b, vecs[i].x);
         check($sformatf("vec%0d_y", i), pix_y_b, vecs[i].y);
         check($sformatf("vec%0d_hs", i), Hsync_b, vecs[i].hs);
         check($sformatf("vec%0d_de", i), de_b, vecs[i].de);
         check($sformatf("vec%0d_r", i), out_R_b, vecs[i].out);
         check($sformatf("vec%0d_gb", i), {out_G_b, out_B_b}, {vecs[i].out, vecs[i].out});
         check($sformatf("vec%0d_ls", i), line_start_b, vecs[i].ls);
      end

      // ---- Small instance: first frame_start from position (2,1) ----
      en_b = 1'b1;
      fs_at = -1;
      for (int i = 1; i <= 100 && fs_at < 0; i++) begin
         edge_a();
         if (frame_start_b) fs_at = i;
      end
      check("small_fs_from_pos10", fs_at, 30);

      // ---- Small instance: one whole frame of 40 clk ----
      fs_at = -1; hs_hi = 0; vs_hi = 0; de_b_cnt = 0; ls_b_cnt = 0; fs_b_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         edge_a();
         if (frame_start_b) begin
            fs_b_cnt++;
            fs_at = i;
         end
         if (Hsync_b) hs_hi++;
         if (Vsync_b) vs_hi++;
         if (de_b) de_b_cnt++;
         if (line_start_b) ls_b_cnt++;
      end
      check("small_fs_period", fs_at, 40);
      check("small_fs_count", fs_b_cnt, 1);
      check("small_hs_high", hs_hi, 10);
      check("small_vs_high", vs_hi, 8);
      check("small_de_count", de_b_cnt, 8);
      check("small_ls_count", ls_b_cnt, 5);

      // ---- Small instance: reset mid-frame, then restart ----
      repeat (15) edge_a();
      check("pre_rst_hs_b", Hsync_b, 1);
      check("pre_rst_x_b", pix_x_b, 7);
      rst_b = 1'b0;
      #1;
      check("midrst_x_b", pix_x_b, 0);
      check("midrst_y_b", pix_y_b, 0);
      check("midrst_hs_b", Hsync_b, 0);
      check("midrst_vs_b", Vsync_b, 0);
      edge_a();
      rst_b = 1'b1;
      fs_at = -1; ls_first = -1;
      for (int i = 1; i <= 100 && fs_at < 0; i++) begin
         edge_a();
         if (ls_first < 0 && line_start_b) ls_first = i;
         if (frame_start_b) fs_at = i;
      end
      check("restart_first_ls", ls_first, 8);
      check("restart_first_fs", fs_at, 40);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Safety net so the run always terminates
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
